unified_mem_arbiter: RTL

- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (lw/sw and byte loads/stores).
- Serialises accesses and applies fixed priority with a starvation guard.
- Drives the memory port and returns data plus a one-cycle ready to the winning stage.
- Exports a pipeline stall while any request is unserved. Sits between the IF/MEM stage modules and the RAM, inside MIPS.

---
 rtl/unified_mem_arbiter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port unified RAM between instruction fetch (IF, read-only)
// and the data stage (MEM, loads/stores with byte enables). Accesses are
// serialised. MEM has fixed priority, but a starvation guard forces an IF grant
// after IF_STARVE_MAX consecutive MEM grants made while IF was waiting.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   if_req/if_addr  fetch request (held until if_ready) and byte address
//   if_rdata        last fetched word; if_ready is a one-cycle completion pulse
//   mem_req/we/addr/wdata/be
//                   data request (held until mem_ready), 1=store / 0=load
//   mem_rdata       last loaded word; mem_ready is a one-cycle completion pulse
//   ram_en/we/addr/wdata/be
//                   registered memory port, ram_en high for one cycle per access
//   ram_rdata       memory read data, valid LATENCY cycles after the ram_en cycle
//   stall           some request is still unserved this cycle
//   misalign        sticky: IF was granted with a non-word-aligned address
//
// Optional feature (macro MEM_ARB_PERF_EN): adds perf_stall_cycles,
// perf_if_grants and perf_mem_grants, 32-bit wrapping counters cleared by rst.
//
// Timing: request sampled in IDLE at edge 0 -> ram_en in cycle 1 ->
// ready in cycle LATENCY+2; one access per LATENCY+3 cycles back to back.
module unified_mem_arbiter #(
  parameter int AW            = 32,
  parameter int LATENCY       = 2,
  parameter int IF_STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_be,
  output logic [31:0]   mem_rdata,
  output logic          mem_ready,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_be,
  input  logic [31:0]   ram_rdata,
  output logic          stall,
  output logic          misalign
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_stall_cycles,
  output logic [31:0]   perf_if_grants,
  output logic [31:0]   perf_mem_grants
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int            SW         = (IF_STARVE_MAX < 1) ? 1 : $clog2(IF_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(IF_STARVE_MAX);
  // WAIT counts down to 0; at 0 the read data is on ram_rdata. LATENCY==1
  // loads 0, so WAIT captures on its first cycle.
  localparam logic [3:0]    WAIT_INIT  = 4'(LATENCY - 1);

  logic [1:0]    state_q, state_d;
  logic          own_if_q, own_if_d;      // 1: current access belongs to IF
  logic [3:0]    wcnt_q, wcnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic [3:0]    ram_be_q, ram_be_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;
  logic          if_ready_q, if_ready_d;
  logic          mem_ready_q, mem_ready_d;
  logic          misalign_q, misalign_d;

  logic          if_win, grant_if, grant_mem;

  // IF only beats a pending MEM request once the guard has saturated.
  assign if_win    = if_req & (~mem_req | (starve_q == STARVE_MAX));
  assign grant_if  = (state_q == S_IDLE) & if_win;
  assign grant_mem = (state_q == S_IDLE) & mem_req & ~if_win;

  always_comb begin
    state_d     = state_q;
    own_if_d    = own_if_q;
    wcnt_d      = wcnt_q;
    starve_d    = starve_q;
    ram_en_d    = 1'b0;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_d    = ram_be_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    misalign_d  = misalign_q;

    case (state_q)
      S_IDLE: begin
        if (grant_if) begin
          own_if_d   = 1'b1;
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = if_addr;
          ram_be_d   = 4'hF;
          starve_d   = '0;
          if (if_addr[1:0] != 2'b00) misalign_d = 1'b1;
          state_d    = S_ACCESS;
        end else if (grant_mem) begin
          own_if_d    = 1'b0;
          ram_en_d    = 1'b1;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          ram_be_d    = mem_be;
          // Only MEM grants that actually made IF wait count toward the guard.
          if (!if_req)                     starve_d = '0;
          else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        wcnt_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          // Stores leave the requester's rdata untouched.
          if (!ram_we_q) begin
            if (own_if_q) if_rdata_d  = ram_rdata;
            else          mem_rdata_d = ram_rdata;
          end
          if (own_if_q) if_ready_d  = 1'b1;
          else          mem_ready_d = 1'b1;
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      own_if_q    <= 1'b0;
      wcnt_q      <= 4'd0;
      starve_q    <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'd0;
      ram_be_q    <= 4'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_if_q    <= own_if_d;
      wcnt_q      <= wcnt_d;
      starve_q    <= starve_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_q    <= ram_be_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      misalign_q  <= misalign_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_be    = ram_be_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign misalign  = misalign_q;
  assign stall     = (if_req & ~if_ready_q) | (mem_req & ~mem_ready_q);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_if_q, perf_mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_if_q    <= 32'd0;
      perf_mem_q   <= 32'd0;
    end else begin
      if (stall)     perf_stall_q <= perf_stall_q + 32'd1;
      if (grant_if)  perf_if_q    <= perf_if_q + 32'd1;
      if (grant_mem) perf_mem_q   <= perf_mem_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_if_grants    = perf_if_q;
  assign perf_mem_grants   = perf_mem_q;
`endif

endmodule
